fetch_pair_queue: RTL and testbench
===================================

Name: fetch_pair_queue

Overview:
- Instruction fetch sequencer and buffer sitting in front of the dual-issue scheduling assistant.
- Owns the fetch PC, issues word addresses to instruction memory, and buffers returned words with their PCs in a circular queue.
- Presents the two oldest entries as instruction0/instruction1 and drives nothing_filled.
- Retires 0, 1 or 2 entries per cycle as directed by the issue stage; flushes on branch/jump redirect.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- fetch_addr  out  32  word address presented to instruction memory (= fetch PC)
- fetch_valid  in  1  memory returns fetch_data for fetch_addr this cycle
- fetch_data  in  32  instruction word for fetch_addr
- fetch_ready  out  1  queue can accept a word this cycle
- pop_count  in  2  entries retired this cycle by the issue stage (0/1/2; 3 treated as 2)
- redirect  in  1  flush queue and reload fetch PC
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- instruction0  out  32  oldest entry, 32'h0 if none
- instruction1  out  32  second-oldest entry, 32'h0 if fewer than 2
- pc0  out  32  PC of instruction0, 32'h0 if none
- pc1  out  32  PC of instruction1, 32'h0 if fewer than 2
- nothing_filled  out  1  queue empty
- valid_count  out  $clog2(DEPTH)+1  current occupancy
- underflow_err  out  1  sticky: pop_count exceeded occupancy

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous, active-high.
- Reset:
  - rd_ptr=0, wr_ptr=0, count=0, fetch PC=RESET_PC, underflow_err=0.
  - Consequent outputs: nothing_filled=1, fetch_ready=1, instruction0/1=0, pc0/1=0, valid_count=0, fetch_addr=RESET_PC.
  - Reset asserted mid-operation discards all entries, exactly as at power-up.
- State: ring of DEPTH entries {pc[31:0], instr[31:0]}; rd_ptr, wr_ptr wrap modulo DEPTH; count in 0..DEPTH.
- fetch_ready = (count < DEPTH). Combinational from registered count only; not raised by a same-cycle pop.
- Push:
  - Condition: fetch_valid && fetch_ready && !redirect.
  - Writes {fetch PC, fetch_data} at wr_ptr; wr_ptr+1; fetch PC += 4 (wraps at 2^32).
- Pop:
  - pop_eff = min(pop_count clamped to 2, count). rd_ptr += pop_eff.
  - If pop_count > count (after clamp), set underflow_err=1; it stays set until rst.
- Count update: count_next = count + push - pop_eff. Simultaneous push and pop is legal; a push to slot rd_ptr is never lost.
- Redirect:
  - Highest priority after rst: count=0, rd_ptr=wr_ptr=0, fetch PC={redirect_pc[31:2],2'b00}.
  - Same-cycle push and pop are ignored; underflow is not flagged.
- Outputs are combinational from registered state:
  - instruction0/pc0 = entry[rd_ptr] when count>=1.
  - instruction1/pc1 = entry[rd_ptr+1 mod DEPTH] when count>=2.
  - Otherwise 0; the scheduler treats 32'h0 as a disabled slot.
- Latency:
  - A word accepted in cycle N is visible on an output in cycle N+1.
  - A redirect in cycle N gives fetch_addr=redirect_pc in cycle N+1, and the first new instruction appears no earlier than N+2.
- Hold: with pop_count=0 and no push/redirect, all outputs remain stable (freeze behaviour).
- Wrap-around: pair output across the ring end (rd_ptr=DEPTH-1) returns entry[DEPTH-1] and entry[0].

Decomposition:
- Shared package fetch_pkg holds:
  - typedef struct packed fq_entry_t {logic [31:0] pc; logic [31:0] instr;}.
  - localparam NOP_INSTR=32'h0.
  - localparam PC_STEP=32'd4.
- One sub-module: fq_ring_storage, a DEPTH x fq_entry_t register array with one write port and two combinational read ports (rd_ptr, rd_ptr+1). Pointer, count, PC and error logic stay in fetch_pair_queue.

Test Plan:
- Reset → nothing_filled=1, fetch_addr=0, fetch_ready=1. Push 3 words with pop=0 → valid_count=3, instruction0=word@0, instruction1=word@4, pc1=4, fetch_addr=0xC.
- Fill to 8 with pop=0 → fetch_ready=0. Assert fetch_valid with push + pop_count=1 in the same cycle → no push, count=7, next cycle fetch_ready=1.
- Steady state count=4, push each cycle, pop_count=2 → count decrements by 1 per cycle. Check ring wrap: at rd_ptr=7, pc0/pc1 are consecutive PCs spanning slots 7 and 0.
- count=1, pop_count=2 → count=0, underflow_err=1 and stays 1 through 10 further cycles. instruction1=0 whenever count<2.
- count=5, redirect=1, redirect_pc=0x0000_0103, fetch_valid=1, pop_count=2 → next cycle count=0, nothing_filled=1, fetch_addr=0x100, underflow_err unchanged.
- rst asserted with count=6 and fetch PC=0x40 → next cycle all outputs at reset values, fetch_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fq_ring_storage.sv
// Ring of fetch entries: one write port and two combinational read ports
// at rd_ptr and rd_ptr+1. Payload is not reset; validity lives in the owner's count.
module fq_ring_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr_i,
    input  fq_entry_t                wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
    output fq_entry_t                rd_data0_o,
    output fq_entry_t                rd_data1_o
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_nxt;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    // DEPTH is a power of two, so the pointer add wraps on its own.
    assign rd_ptr_nxt = rd_ptr_i + AW'(1);
    assign rd_data0_o = mem_q[rd_ptr_i];
    assign rd_data1_o = mem_q[rd_ptr_nxt];

endmodule

// File: rtl/fetch_pair_queue.sv
// Fetch sequencer and circular instruction buffer presenting the two oldest
// entries to the dual-issue scheduler; retires 0..2 per cycle, flushes on redirect.
module fetch_pair_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                fetch_addr,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_data,
    output logic                       fetch_ready,
    input  logic [1:0]                 pop_count,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                instruction0,
    output logic [31:0]                instruction1,
    output logic [31:0]                pc0,
    output logic [31:0]                pc1,
    output logic                       nothing_filled,
    output logic [$clog2(DEPTH):0]     valid_count,
    output logic                       underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic          uf_q, uf_d;

    logic [CW-1:0] pop_req;
    logic [CW-1:0] pop_eff;
    logic          push;
    fq_entry_t     wr_entry;
    fq_entry_t     rd_entry0;
    fq_entry_t     rd_entry1;

    assign fetch_ready = (count_q < CW'(DEPTH));
    assign push        = fetch_valid && fetch_ready && !redirect;
    assign pop_req     = (pop_count == 2'd3) ? CW'(2) : CW'(pop_count);
    assign pop_eff     = (pop_req > count_q) ? count_q : pop_req;
    assign wr_entry    = '{pc: pc_q, instr: fetch_data};

    always_comb begin
        rd_ptr_d = rd_ptr_q + pop_eff[AW-1:0];
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - pop_eff;
        pc_d     = push ? (pc_q + PC_STEP) : pc_q;
        uf_d     = uf_q | (pop_req > count_q);
        // Redirect discards this cycle's push and pop, and never flags underflow.
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {redirect_pc[31:2], 2'b00};
            uf_d     = uf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
            uf_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            uf_q     <= uf_d;
        end
    end

    fq_ring_storage #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .wr_en_i    (push),
        .wr_ptr_i   (wr_ptr_q),
        .wr_data_i  (wr_entry),
        .rd_ptr_i   (rd_ptr_q),
        .rd_data0_o (rd_entry0),
        .rd_data1_o (rd_entry1)
    );

    assign fetch_addr     = pc_q;
    assign nothing_filled = (count_q == '0);
    assign valid_count    = count_q;
    assign underflow_err  = uf_q;
    assign instruction0   = (count_q >= CW'(1)) ? rd_entry0.instr : NOP_INSTR;
    assign pc0            = (count_q >= CW'(1)) ? rd_entry0.pc    : 32'h0;
    assign instruction1   = (count_q >= CW'(2)) ? rd_entry1.instr : NOP_INSTR;
    assign pc1            = (count_q >= CW'(2)) ? rd_entry1.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue: fill, full back-pressure, ring wrap,
// underflow stickiness, redirect flush and mid-run reset.
module tb_fetch_pair_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [1:0]  pop_count;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction0, instruction1, pc0, pc1;
    logic        nothing_filled;
    logic [3:0]  valid_count;
    logic        underflow_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc;

    fetch_pair_queue #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .pop_count      (pop_count),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instruction0   (instruction0),
        .instruction1   (instruction1),
        .pc0            (pc0),
        .pc1            (pc1),
        .nothing_filled (nothing_filled),
        .valid_count    (valid_count),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_valid = 1'b1;
            fetch_data  = word(exp_pc);
            step();
            exp_pc += 32'd4;
        end
        fetch_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; pop_count = 2'd0;
        redirect = 1'b0; redirect_pc = '0;
        step(); step();
        rst = 1'b0;
        exp_pc = 32'h0;
        chk("rst_empty", 32'(nothing_filled), 32'd1);
        chk("rst_addr", fetch_addr, 32'h0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_count", 32'(valid_count), 32'd0);
        chk("rst_instr0", instruction0, 32'h0);
        chk("rst_uf", 32'(underflow_err), 32'd0);

        // Three words, no pops.
        push_n(3);
        chk("p3_count", 32'(valid_count), 32'd3);
        chk("p3_instr0", instruction0, word(32'h0));
        chk("p3_instr1", instruction1, word(32'h4));
        chk("p3_pc1", pc1, 32'h4);
        chk("p3_addr", fetch_addr, 32'hC);
        step();
        chk("hold_instr0", instruction0, word(32'h0));
        chk("hold_count", 32'(valid_count), 32'd3);

        // Fill to full, then offer a word while popping one.
        push_n(5);
        chk("full_count", 32'(valid_count), 32'd8);
        chk("full_ready", 32'(fetch_ready), 32'd0);
        fetch_valid = 1'b1; fetch_data = word(exp_pc); pop_count = 2'd1;
        step();
        fetch_valid = 1'b0; pop_count = 2'd0;
        chk("fullpop_count", 32'(valid_count), 32'd7);
        chk("fullpop_ready", 32'(fetch_ready), 32'd1);
        chk("fullpop_addr", fetch_addr, 32'h20);
        chk("fullpop_pc0", pc0, 32'h4);

        // Drain to 4 (rd_ptr=4), then push every cycle while popping.
        pop_count = 2'd2; step();
        pop_count = 2'd1; step();
        chk("c4_count", 32'(valid_count), 32'd4);
        chk("c4_pc0", pc0, 32'h10);
        fetch_valid = 1'b1; fetch_data = word(exp_pc); pop_count = 2'd2;
        step(); exp_pc += 32'd4;
        chk("ss_count3", 32'(valid_count), 32'd3);
        chk("ss_pc0", pc0, 32'h18);
        fetch_data = word(exp_pc); pop_count = 2'd1;
        step(); exp_pc += 32'd4;
        chk("wrap_count", 32'(valid_count), 32'd3);
        chk("wrap_pc0", pc0, 32'h1C);
        chk("wrap_pc1", pc1, 32'h20);
        chk("wrap_instr0", instruction0, word(32'h1C));
        chk("wrap_instr1", instruction1, word(32'h20));
        fetch_data = word(exp_pc); pop_count = 2'd2;
        step(); exp_pc += 32'd4;
        chk("ss_count2", 32'(valid_count), 32'd2);
        chk("ss2_pc0", pc0, 32'h24);
        chk("ss2_pc1", pc1, 32'h28);
        fetch_valid = 1'b0;

        // Down to one entry, then over-pop.
        pop_count = 2'd1; step();
        chk("c1_count", 32'(valid_count), 32'd1);
        chk("c1_instr1", instruction1, 32'h0);
        chk("c1_pc0", pc0, 32'h28);
        chk("c1_uf", 32'(underflow_err), 32'd0);
        pop_count = 2'd2; step();
        pop_count = 2'd0;
        chk("uf_count", 32'(valid_count), 32'd0);
        chk("uf_empty", 32'(nothing_filled), 32'd1);
        chk("uf_instr0", instruction0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("uf_sticky", 32'(underflow_err), 32'd1);
        end

        // Five entries, then redirect with a competing push and pop.
        push_n(5);
        chk("r5_count", 32'(valid_count), 32'd5);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        fetch_valid = 1'b1; fetch_data = word(32'hDEAD); pop_count = 2'd2;
        step();
        redirect = 1'b0; pop_count = 2'd0; exp_pc = 32'h100;
        chk("rd_count", 32'(valid_count), 32'd0);
        chk("rd_empty", 32'(nothing_filled), 32'd1);
        chk("rd_addr", fetch_addr, 32'h100);
        chk("rd_uf", 32'(underflow_err), 32'd1);
        fetch_data = word(exp_pc);
        step(); exp_pc += 32'd4;
        fetch_valid = 1'b0;
        chk("rd_first_pc0", pc0, 32'h100);
        chk("rd_first_instr0", instruction0, word(32'h100));

        // Build count=6 ending at fetch PC 0x40, then reset.
        redirect = 1'b1; redirect_pc = 32'h28;
        step();
        redirect = 1'b0; exp_pc = 32'h28;
        push_n(6);
        chk("pre_rst_count", 32'(valid_count), 32'd6);
        chk("pre_rst_addr", fetch_addr, 32'h40);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_count", 32'(valid_count), 32'd0);
        chk("rst2_empty", 32'(nothing_filled), 32'd1);
        chk("rst2_addr", fetch_addr, 32'h0);
        chk("rst2_ready", 32'(fetch_ready), 32'd1);
        chk("rst2_instr0", instruction0, 32'h0);
        chk("rst2_instr1", instruction1, 32'h0);
        chk("rst2_pc0", pc0, 32'h0);
        chk("rst2_pc1", pc1, 32'h0);
        chk("rst2_uf", 32'(underflow_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
